instruction_fetch: RTL and testbench

Downstream neighbour of the program-counter stage: reads the current `program_counter` and issues a request to instruction ROM. On ROM acknowledge it pulses `pc_advance` so the PC stage steps, and queues the returned word with its address in a small FIFO. Decode drains the FIFO with a valid/ready handshake. Fetch throttles itself when the FIFO is full.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 43 ++++
 rtl/instruction_fetch.sv | 75 +++++++
 tb/tb_instruction_fetch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state, entry type and default widths for the instruction fetch stage
package fetch_pkg;
  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, FETCH, FAULT} fetch_state_t;
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetched entries with async active-low clear
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         push,
  input  logic                         pop,
  input  T                             din,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + PW'(1);
      end
      if (do_pop) rp <= rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: ROM fetch stage feeding a small instruction FIFO; FETCH_TIMEOUT_EN adds a sticky ROM-timeout fault
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter int ROM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              is_powered_on,
  input  logic [ADDR_W-1:0] program_counter,
  output logic              pc_advance,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_fault
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;
  fetch_state_t state, state_n;
  entry_t head, tail;
  logic [CW-1:0] count;
  logic full, empty, pop, tmo_hit;
  assign rom_req = state == FETCH;
  assign rom_addr = program_counter;
  assign pc_advance = rom_req & rom_ack;
  assign instr_valid = !empty;
  assign pop = instr_valid & instr_ready;
  assign tail = '{pc: program_counter, instr: rom_data};
  assign instr = head.instr;
  assign instr_pc = head.pc;
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .clr_n (is_powered_on),
    .push  (pc_advance),
    .pop   (pop),
    .din   (tail),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(ROM_TIMEOUT + 1);
  logic [TW-1:0] tmo;
  assign tmo_hit = rom_req & !rom_ack & (tmo == TW'(ROM_TIMEOUT - 1));
  assign fetch_fault = state == FAULT;
  always_ff @(posedge clk or negedge is_powered_on) begin
    if (!is_powered_on) tmo <= '0;
    else if (rom_req) tmo <= rom_ack ? '0 : tmo + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
  assign fetch_fault = ROM_TIMEOUT < 0;
`endif
  always_comb begin
    state_n = (state == IDLE)  ? (full ? IDLE : FETCH) :
              (state == FETCH) ? (rom_ack ? (((count < CW'(FIFO_DEPTH - 1)) | pop) ? FETCH : IDLE)
                                          : (tmo_hit ? FAULT : FETCH)) :
              state;
  end
  always_ff @(posedge clk or negedge is_powered_on) begin
    if (!is_powered_on) state <= IDLE;
    else state <= state_n;
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven and directed checks of the fetch stage against hand-computed traces
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        is_powered_on = 1'b1;
  logic        rom_ack = 1'b0;
  logic        instr_ready = 1'b0;
  logic [15:0] program_counter = 16'h0;
  logic [15:0] rom_data = 16'h0;
  logic        pc_advance, rom_req, instr_valid, fetch_fault;
  logic [15:0] rom_addr, instr, instr_pc;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        req;
    logic        adv;
    logic        vld;
    logic [15:0] pc;
    logic [15:0] ins;
  } vec_t;
  vec_t tbl[$];
  instruction_fetch dut (
    .clk             (clk),
    .is_powered_on   (is_powered_on),
    .program_counter (program_counter),
    .pc_advance      (pc_advance),
    .rom_req         (rom_req),
    .rom_addr        (rom_addr),
    .rom_ack         (rom_ack),
    .rom_data        (rom_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .fetch_fault     (fetch_fault)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic rst, logic ack, logic rdy, logic req, logic adv, logic vld,
                             logic [15:0] pc, logic [15:0] ins);
    vec_t r;
    r.rst = rst; r.ack = ack; r.rdy = rdy; r.req = req;
    r.adv = adv; r.vld = vld; r.pc = pc; r.ins = ins;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic ack, input logic rdy);
    rom_ack = ack;
    instr_ready = rdy;
    rom_data = program_counter ^ 16'hA5A5;
    #1;
  endtask
  task automatic tick();
    logic adv;
    adv = pc_advance;
    @(posedge clk);
    #1;
    if (adv) program_counter = program_counter + 16'd1;
  endtask
  task automatic rst_to(input logic [15:0] pc);
    is_powered_on = 1'b0;
    rom_ack = 1'b0;
    instr_ready = 1'b0;
    @(posedge clk);
    #1;
    program_counter = pc;
    is_powered_on = 1'b1;
  endtask
  initial begin
    // zero-wait ROM, decode always ready: one fetch per cycle, no gaps
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 1, 1, 1, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 1, 1, 1, 1, 1, 16'h0000, 16'hA5A5));
    tbl.push_back(v(0, 1, 1, 1, 1, 1, 16'h0001, 16'hA5A4));
    tbl.push_back(v(0, 1, 1, 1, 1, 1, 16'h0002, 16'hA5A7));
    tbl.push_back(v(0, 1, 1, 1, 1, 1, 16'h0003, 16'hA5A6));
    // 3-cycle ROM latency with decode stalled: fill, throttle, resume
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 16'h0000, 16'hA5A5));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 16'h0000, 16'hA5A5));
    tbl.push_back(v(0, 1, 0, 1, 1, 1, 16'h0000, 16'hA5A5));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 16'h0000, 16'hA5A5));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 16'h0000, 16'hA5A5));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 16'h0000, 16'hA5A5));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 16'h0001, 16'hA5A4));
    tbl.push_back(v(0, 1, 0, 1, 1, 1, 16'h0001, 16'hA5A4));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 16'h0001, 16'hA5A4));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 16'h0002, 16'hA5A7));
    tbl.push_back(v(0, 1, 1, 1, 1, 0, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 0, 1, 1, 0, 1, 16'h0003, 16'hA5A6));
    #1 is_powered_on = 1'b0;
    #1;
    chk("reset rom_req", rom_req, 0);
    chk("reset pc_advance", pc_advance, 0);
    chk("reset instr_valid", instr_valid, 0);
    chk("reset fetch_fault", fetch_fault, 0);
    chk("reset instr", instr, 0);
    chk("reset instr_pc", instr_pc, 0);
    foreach (tbl[i]) begin
      if (tbl[i].rst) rst_to(16'h0000);
      drive(tbl[i].ack, tbl[i].rdy);
      chk($sformatf("row%0d rom_req", i), rom_req, tbl[i].req);
      chk($sformatf("row%0d pc_advance", i), pc_advance, tbl[i].adv);
      chk($sformatf("row%0d instr_valid", i), instr_valid, tbl[i].vld);
      if (tbl[i].req) chk($sformatf("row%0d rom_addr", i), rom_addr, program_counter);
      if (tbl[i].vld) begin
        chk($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].pc);
        chk($sformatf("row%0d instr", i), instr, tbl[i].ins);
      end
      tick();
    end
    // PC 0xFFFF is fetched and tagged without wrap
    rst_to(16'hFFFF);
    drive(0, 0);
    chk("ffff idle req", rom_req, 0);
    tick();
    drive(1, 0);
    chk("ffff req", rom_req, 1);
    chk("ffff addr", rom_addr, 16'hFFFF);
    chk("ffff adv", pc_advance, 1);
    tick();
    drive(0, 0);
    chk("ffff adv once", pc_advance, 0);
    chk("ffff valid", instr_valid, 1);
    chk("ffff instr_pc", instr_pc, 16'hFFFF);
    chk("ffff instr", instr, 16'h5A5A);
    tick();
    drive(0, 0);
    chk("pending req", rom_req, 1);
    // async reset mid-transaction
    rom_ack = 1'b1;
    is_powered_on = 1'b0;
    #1;
    chk("midrst rom_req", rom_req, 0);
    chk("midrst pc_advance", pc_advance, 0);
    chk("midrst instr_valid", instr_valid, 0);
    chk("midrst instr", instr, 0);
    chk("midrst instr_pc", instr_pc, 0);
    @(posedge clk);
    #1;
    program_counter = 16'h0010;
    is_powered_on = 1'b1;
    drive(1, 0);
    chk("restart idle req", rom_req, 0);
    chk("restart idle adv", pc_advance, 0);
    tick();
    drive(1, 0);
    chk("restart req", rom_req, 1);
    chk("restart addr", rom_addr, 16'h0010);
    tick();
    drive(0, 0);
    chk("restart instr_pc", instr_pc, 16'h0010);
    chk("restart instr", instr, 16'hA5B5);
    // ROM that never acknowledges
    rst_to(16'h0020);
    drive(0, 0);
    tick();
    for (int k = 0; k < 15; k++) begin
      drive(0, 0);
      chk($sformatf("wait%0d req", k), rom_req, 1);
      chk($sformatf("wait%0d fault", k), fetch_fault, 0);
      tick();
    end
`ifdef FETCH_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      drive(1, 0);
      chk($sformatf("fault%0d flag", k), fetch_fault, 1);
      chk($sformatf("fault%0d req", k), rom_req, 0);
      chk($sformatf("fault%0d adv", k), pc_advance, 0);
      tick();
    end
    is_powered_on = 1'b0;
    #1;
    chk("fault cleared", fetch_fault, 0);
`else
    for (int k = 0; k < 4; k++) begin
      drive(0, 0);
      chk($sformatf("nofault%0d flag", k), fetch_fault, 0);
      chk($sformatf("nofault%0d req", k), rom_req, 1);
      tick();
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
